// File: rtl/crc_chk_pkg.sv
// Shared types and constants for the CRC result checker.
package crc_chk_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        DONE  = 3'd3,
        FAIL  = 3'd4
    } chk_state_e;

    // Bit positions inside the sticky fault vector.
    localparam int unsigned FLT_OVF = 0;
    localparam int unsigned FLT_UNF = 1;
    localparam int unsigned FLT_TMO = 2;

    // Everything the ILA wants to see in one probe.
    typedef struct packed {
        logic [7:0] pkt_in_cnt;
        logic [7:0] res_cnt;
        logic [7:0] err_cnt;
        logic [7:0] first_err_idx;
        logic [2:0] fault;
        logic       done;
        logic       pass;
    } chk_status_t;

    function automatic logic is_terminal(chk_state_e s);
        return (s == DONE) || (s == FAIL);
    endfunction

endpackage

// File: rtl/crc_exp_fifo.sv
// Expected-CRC FIFO: first-word-fall-through head, synchronous flush on rst.
module crc_exp_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (AW + 1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO is only accepted when a pop frees the slot.
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr_q];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
            else if (!do_push && do_pop) cnt_q <= cnt_q - 1'b1;
        end
    end

    // Storage array; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/crc_result_checker.sv
// Compares crc_gen results in order against golden CRCs and reports status.
module crc_result_checker
    import crc_chk_pkg::*;
#(
    parameter int unsigned CRC_WIDTH  = 32,
    parameter logic [7:0]  PKT_LIMIT  = 8'd200,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned MAX_LAT    = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flitEn,
    input  logic                 dlast,
    input  logic [CRC_WIDTH-1:0] crc_out,
    input  logic                 crc_out_vld,
    input  logic [CRC_WIDTH-1:0] exp_crc,
    input  logic                 exp_vld,
    output logic [7:0]           pkt_in_cnt,
    output logic [7:0]           res_cnt,
    output logic [7:0]           err_cnt,
    output logic [7:0]           first_err_idx,
    output logic [CRC_WIDTH-1:0] first_err_got,
    output logic [CRC_WIDTH-1:0] first_err_exp,
    output logic [2:0]           fault,
    output logic                 done,
    output logic                 pass
);

    localparam int unsigned WD_W = $clog2(MAX_LAT + 1);

    chk_state_e           state_q, state_d;
    chk_status_t          st_q, st_d;
    logic [CRC_WIDTH-1:0] got_q, got_d, exp_q, exp_d;
    logic [WD_W-1:0]      wd_q, wd_d;
    logic [CRC_WIDTH-1:0] fifo_head, golden;
    logic                 fifo_empty, fifo_full, fifo_push, fifo_pop;
    logic                 active, cmp_window, eop_cnt, do_cmp;
    logic                 underflow, overflow, mismatch, wd_expire;
    logic [8:0]           outstanding;

    assign active      = ~is_terminal(state_q);
    assign cmp_window  = (state_q == RUN) || (state_q == DRAIN);
    assign eop_cnt     = flitEn & dlast & ((state_q == IDLE) || (state_q == RUN))
                         & (st_q.pkt_in_cnt < PKT_LIMIT);
    assign underflow   = cmp_window & crc_out_vld & fifo_empty & ~exp_vld;
    assign do_cmp      = cmp_window & crc_out_vld & (~fifo_empty | exp_vld);
    // Empty FIFO with a same-cycle golden: compare straight against exp_crc.
    assign golden      = fifo_empty ? exp_crc : fifo_head;
    assign mismatch    = (crc_out != golden);
    assign fifo_pop    = do_cmp & ~fifo_empty;
    assign fifo_push   = exp_vld & ~(do_cmp & fifo_empty);
    assign overflow    = fifo_push & fifo_full & ~fifo_pop;
    assign outstanding = {1'b0, st_q.pkt_in_cnt} - {1'b0, st_q.res_cnt};

    crc_exp_fifo #(
        .WIDTH (CRC_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_exp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (exp_crc),
        .pop   (fifo_pop),
        .head  (fifo_head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Latency watchdog: counts idle cycles while results are owed.
    always_comb begin
        wd_d      = wd_q;
        wd_expire = 1'b0;
        if (active) begin
            if (do_cmp || (outstanding == 9'd0)) begin
                wd_d = '0;
            end else if (wd_q != WD_W'(MAX_LAT)) begin
                wd_d      = wd_q + 1'b1;
                wd_expire = (wd_q == WD_W'(MAX_LAT - 1));
            end
        end
    end

    // Next-state: a registered fault always beats progress toward DONE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (st_q.fault != 3'b000) state_d = FAIL;
                else if (eop_cnt)         state_d = RUN;
            end
            RUN: begin
                if (st_q.fault != 3'b000)              state_d = FAIL;
                else if (st_q.pkt_in_cnt == PKT_LIMIT) state_d = DRAIN;
            end
            DRAIN: begin
                if (st_q.fault != 3'b000)           state_d = FAIL;
                else if (st_q.res_cnt == PKT_LIMIT) state_d = DONE;
            end
            DONE, FAIL: state_d = state_q;
            default:    state_d = IDLE;
        endcase
    end

    // Counters, first-error capture, sticky faults and done/pass.
    always_comb begin
        st_d  = st_q;
        got_d = got_q;
        exp_d = exp_q;
        if (eop_cnt) st_d.pkt_in_cnt = st_q.pkt_in_cnt + 8'd1;
        if (do_cmp) begin
            st_d.res_cnt = st_q.res_cnt + 8'd1;
            if (mismatch) begin
                if (st_q.err_cnt == 8'd0) begin
                    st_d.first_err_idx = st_q.res_cnt;
                    got_d              = crc_out;
                    exp_d              = golden;
                end
                if (st_q.err_cnt != 8'hFF) st_d.err_cnt = st_q.err_cnt + 8'd1;
            end
        end
        if (active) begin
            if (overflow)  st_d.fault[FLT_OVF] = 1'b1;
            if (underflow) st_d.fault[FLT_UNF] = 1'b1;
            if (wd_expire) st_d.fault[FLT_TMO] = 1'b1;
        end
        st_d.done = is_terminal(state_d);
        st_d.pass = (state_d == DONE) && (st_d.err_cnt == 8'd0) && (st_d.fault == 3'b000);
    end

    // State registers; reset wins over every same-cycle event.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            st_q    <= '0;
            got_q   <= '0;
            exp_q   <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            got_q   <= got_d;
            exp_q   <= exp_d;
            wd_q    <= wd_d;
        end
    end

    assign pkt_in_cnt    = st_q.pkt_in_cnt;
    assign res_cnt       = st_q.res_cnt;
    assign err_cnt       = st_q.err_cnt;
    assign first_err_idx = st_q.first_err_idx;
    assign first_err_got = got_q;
    assign first_err_exp = exp_q;
    assign fault         = st_q.fault;
    assign done          = st_q.done;
    assign pass          = st_q.pass;

endmodule

// File: tb/tb_crc_result_checker.sv
// Self-checking bench for crc_result_checker with a small run-level model.
module tb_crc_result_checker;

    localparam int unsigned W     = 32;
    localparam logic [7:0]  LIMIT = 8'd4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LAT   = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flitEn = 1'b0, dlast = 1'b0, crc_out_vld = 1'b0, exp_vld = 1'b0;
    logic [W-1:0]  crc_out = '0, exp_crc = '0;
    logic [7:0]    pkt_in_cnt, res_cnt, err_cnt, first_err_idx;
    logic [W-1:0]  first_err_got, first_err_exp;
    logic [2:0]    fault;
    logic          done, pass;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    logic [W-1:0] gold_v [4];
    logic [W-1:0] dut_v  [4];

    always #5 clk = ~clk;

    crc_result_checker #(
        .CRC_WIDTH  (W),
        .PKT_LIMIT  (LIMIT),
        .FIFO_DEPTH (DEPTH),
        .MAX_LAT    (LAT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flitEn        (flitEn),
        .dlast         (dlast),
        .crc_out       (crc_out),
        .crc_out_vld   (crc_out_vld),
        .exp_crc       (exp_crc),
        .exp_vld       (exp_vld),
        .pkt_in_cnt    (pkt_in_cnt),
        .res_cnt       (res_cnt),
        .err_cnt       (err_cnt),
        .first_err_idx (first_err_idx),
        .first_err_got (first_err_got),
        .first_err_exp (first_err_exp),
        .fault         (fault),
        .done          (done),
        .pass          (pass)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- run-level model ----------------
    int unsigned  m_pkts = 0, m_res = 0, m_errs = 0, m_quiet = 0;
    logic [2:0]   m_fault = '0;
    logic [7:0]   m_idx = '0;
    logic [W-1:0] m_got = '0, m_exp = '0;
    bit           m_started = 0, m_draining = 0, m_ok = 0, m_failed = 0;
    logic [W-1:0] m_q [$];

    always @(posedge clk) begin : model
        int unsigned  old_pkts, old_res;
        logic [2:0]   old_fault;
        bit           live, window, eop, cmp, bypass;
        logic [W-1:0] golden;
        if (rst) begin
            m_pkts = 0; m_res = 0; m_errs = 0; m_quiet = 0; m_fault = '0;
            m_idx = '0; m_got = '0; m_exp = '0;
            m_started = 0; m_draining = 0; m_ok = 0; m_failed = 0;
            m_q.delete();
        end else begin
            old_pkts  = m_pkts;
            old_res   = m_res;
            old_fault = m_fault;
            live      = !(m_ok || m_failed);
            window    = live && m_started;
            eop = 0; cmp = 0; bypass = 0;
            if (flitEn && dlast && live && m_pkts < LIMIT) begin
                m_pkts++;
                eop = 1;
            end
            if (crc_out_vld && window) begin
                if (m_q.size() == 0 && !exp_vld) begin
                    m_fault[1] = 1'b1;
                end else begin
                    if (m_q.size() == 0) begin
                        golden = exp_crc;
                        bypass = 1;
                    end else begin
                        golden = m_q.pop_front();
                    end
                    if (crc_out !== golden) begin
                        if (m_errs == 0) begin
                            m_idx = 8'(old_res);
                            m_got = crc_out;
                            m_exp = golden;
                        end
                        if (m_errs < 255) m_errs++;
                    end
                    m_res++;
                    cmp = 1;
                end
            end
            if (exp_vld && !bypass) begin
                if (m_q.size() < DEPTH) m_q.push_back(exp_crc);
                else if (live) m_fault[0] = 1'b1;
            end
            if (live) begin
                if (cmp || old_pkts == old_res) m_quiet = 0;
                else begin
                    m_quiet++;
                    if (m_quiet == LAT) m_fault[2] = 1'b1;
                end
            end
            if (live) begin
                if (old_fault != 3'b000)  m_failed = 1;
                else if (!m_started)      m_started = eop;
                else if (!m_draining)     m_draining = (old_pkts == LIMIT);
                else if (old_res == LIMIT) m_ok = 1;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("cyc_pkt_in_cnt", 32'(pkt_in_cnt), 32'(m_pkts));
            chk("cyc_res_cnt", 32'(res_cnt), 32'(m_res));
            chk("cyc_err_cnt", 32'(err_cnt), 32'(m_errs));
            chk("cyc_first_err_idx", 32'(first_err_idx), 32'(m_idx));
            chk("cyc_first_err_got", first_err_got, m_got);
            chk("cyc_first_err_exp", first_err_exp, m_exp);
            chk("cyc_fault", 32'(fault), 32'(m_fault));
            chk("cyc_done", 32'(done), 32'(m_ok || m_failed));
            chk("cyc_pass", 32'(pass), 32'(m_ok && m_errs == 0 && m_fault == 3'b000));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic f, input logic d, input logic cv, input logic [W-1:0] c,
                         input logic ev, input logic [W-1:0] e);
        @(negedge clk);
        flitEn = f; dlast = d; crc_out_vld = cv; crc_out = c; exp_vld = ev; exp_crc = e;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    // One reset cycle; noisy drives every event input high to prove rst priority.
    task automatic do_reset(input logic noisy);
        @(negedge clk);
        rst = 1'b1;
        flitEn = noisy; dlast = noisy; crc_out_vld = noisy; exp_vld = noisy;
        crc_out = 32'h0BAD_0BAD; exp_crc = 32'h0BAD_0BAD;
        @(negedge clk);
        rst = 1'b0;
        flitEn = 1'b0; dlast = 1'b0; crc_out_vld = 1'b0; exp_vld = 1'b0;
        crc_out = '0; exp_crc = '0;
    endtask

    // Four packets: eop, a non-last flit, then the result. Golden either
    // pushed two cycles ahead or supplied in the result cycle (bypass).
    task automatic run_stream(input bit byp);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, '0, !byp, gold_v[i]);
            drive(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
            drive(1'b0, 1'b0, 1'b1, dut_v[i], byp, gold_v[i]);
        end
        idle(3);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_pkt"}, 32'(pkt_in_cnt), 32'd0);
        chk({tag, "_res"}, 32'(res_cnt), 32'd0);
        chk({tag, "_err"}, 32'(err_cnt), 32'd0);
        chk({tag, "_fault"}, 32'(fault), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_pass"}, 32'(pass), 32'd0);
    endtask

    initial begin
        gold_v[0] = 32'h1111_1111; gold_v[1] = 32'h2222_2222;
        gold_v[2] = 32'h1234_5678; gold_v[3] = 32'h4444_4444;
        @(posedge clk);
        chk_on = 1'b1;
        do_reset(1'b0);
        chk_zero("reset");

        // Clean run.
        for (int i = 0; i < 4; i++) dut_v[i] = gold_v[i];
        run_stream(1'b0);
        chk("clean_res", 32'(res_cnt), 32'd4);
        chk("clean_err", 32'(err_cnt), 32'd0);
        chk("clean_fault", 32'(fault), 32'd0);
        chk("clean_done", 32'(done), 32'd1);
        chk("clean_pass", 32'(pass), 32'd1);
        drive(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
        idle(2);
        chk("clean_extra_eop", 32'(pkt_in_cnt), 32'd4);

        // Third result corrupted.
        do_reset(1'b0);
        dut_v[2] = 32'hDEAD_BEEF;
        run_stream(1'b0);
        chk("mm_err", 32'(err_cnt), 32'd1);
        chk("mm_idx", 32'(first_err_idx), 32'd2);
        chk("mm_got", first_err_got, 32'hDEAD_BEEF);
        chk("mm_exp", first_err_exp, 32'h1234_5678);
        chk("mm_done", 32'(done), 32'd1);
        chk("mm_pass", 32'(pass), 32'd0);
        dut_v[2] = gold_v[2];

        // Result with nothing to compare against.
        do_reset(1'b0);
        drive(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
        drive(1'b0, 1'b0, 1'b1, 32'h0000_CAFE, 1'b0, '0);
        idle(1);
        chk("unf_fault", 32'(fault), 32'b010);
        chk("unf_done_early", 32'(done), 32'd0);
        chk("unf_res", 32'(res_cnt), 32'd0);
        idle(1);
        chk("unf_done", 32'(done), 32'd1);
        chk("unf_pass", 32'(pass), 32'd0);

        // Overflow on the fifth push into a four-deep FIFO.
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 32'(i + 16));
        chk("ovf_none_at_4", 32'(fault), 32'd0);
        idle(1);
        chk("ovf_fault", 32'(fault), 32'b001);
        idle(1);
        chk("ovf_done", 32'(done), 32'd1);

        // Watchdog expiry.
        do_reset(1'b0);
        drive(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
        idle(8);
        chk("tmo_not_yet", 32'(fault), 32'd0);
        idle(1);
        chk("tmo_fault", 32'(fault), 32'b100);
        idle(1);
        chk("tmo_done", 32'(done), 32'd1);

        // Result lands on the cycle the watchdog would expire.
        do_reset(1'b0);
        drive(1'b1, 1'b1, 1'b0, '0, 1'b1, 32'h5A5A_A5A5);
        idle(7);
        drive(1'b0, 1'b0, 1'b1, 32'h5A5A_A5A5, 1'b0, '0);
        idle(12);
        chk("tmo_edge_fault", 32'(fault), 32'd0);
        chk("tmo_edge_res", 32'(res_cnt), 32'd1);
        chk("tmo_edge_done", 32'(done), 32'd0);

        // Reset in DRAIN with two results owed and two goldens queued.
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, '0, 1'b1, gold_v[i]);
        drive(1'b1, 1'b1, 1'b1, gold_v[0], 1'b0, '0);
        drive(1'b0, 1'b0, 1'b1, gold_v[1], 1'b0, '0);
        idle(1);
        chk("drain_pkt", 32'(pkt_in_cnt), 32'd4);
        chk("drain_res", 32'(res_cnt), 32'd2);
        chk("drain_done", 32'(done), 32'd0);
        do_reset(1'b1);
        chk_zero("midrst");
        run_stream(1'b1);
        chk("post_rst_res", 32'(res_cnt), 32'd4);
        chk("post_rst_err", 32'(err_cnt), 32'd0);
        chk("post_rst_pass", 32'(pass), 32'd1);

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/crc_result_checker.md
Name: crc_result_checker

Overview:
- Receiving end of the on-board CRC correctness harness.
- Monitors the packet stream driven into crc_gen (flitEn/dlast) and the generator's result stream (crc_out/crc_out_vld).
- Compares each result in order against a golden CRC pushed by a reference source, and produces pass/fail status, counters and first-error capture for the ILA.
- Terminates after PKT_LIMIT packets, or on a protocol or latency fault.

Parameters:
- CRC_WIDTH, 32, width of the CRC values.
- PKT_LIMIT, 8'd200, number of packets per run (bit [7:0]); 0 is illegal.
- FIFO_DEPTH, 16, expected-CRC FIFO entries; power of two, ≥2.
- MAX_LAT, 64, cycles allowed between results while packets are outstanding; ≥2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flitEn  in  1  input flit valid (to crc_gen)
- dlast  in  1  last flit of packet; qualified by flitEn
- crc_out  in  CRC_WIDTH  DUT result
- crc_out_vld  in  1  DUT result valid
- exp_crc  in  CRC_WIDTH  golden CRC
- exp_vld  in  1  golden CRC valid; push into FIFO
- pkt_in_cnt  out  8  packets observed entering DUT
- res_cnt  out  8  results compared
- err_cnt  out  8  mismatches, saturating at 255
- first_err_idx  out  8  res_cnt value of first mismatch
- first_err_got  out  CRC_WIDTH  DUT CRC at first mismatch
- first_err_exp  out  CRC_WIDTH  golden CRC at first mismatch
- fault  out  3  sticky {timeout, underflow, overflow}
- done  out  1  run finished (DONE or FAIL)
- pass  out  1  finished, no mismatch, no fault

Behaviour:
- Reset: all outputs 0, FIFO flushed, state IDLE. Reset mid-run discards all state and takes priority over every other event in the same cycle.
- End-of-packet event eop = flitEn & dlast. Counts only in IDLE/RUN while pkt_in_cnt < PKT_LIMIT; eops beyond the limit are ignored without error.
- FIFO:
  - exp_vld pushes; a pop occurs on a compare.
  - Push when full with no same-cycle pop: data dropped, fault[0] set.
  - Simultaneous push+pop when full is legal.
- Compare happens on crc_out_vld in RUN/DRAIN:
  - Golden value is the FIFO head. If the FIFO is empty and exp_vld is high the same cycle, exp_crc is used directly (bypass; nothing stored).
  - If the FIFO is empty and exp_vld is low: fault[1] set, no compare, res_cnt unchanged.
  - Otherwise res_cnt++.
  - On mismatch, err_cnt++ (saturating). If err_cnt was 0, first_err_* are captured from pre-increment res_cnt, crc_out and the golden value.
  - All counters and captures register one cycle after the event.
- crc_out_vld in IDLE or DONE/FAIL is ignored.
- Outstanding count = pkt_in_cnt − res_cnt (9-bit internal).
- Watchdog:
  - Cleared on any compare or when outstanding == 0; increments otherwise.
  - Reaching MAX_LAT sets fault[2].
- FSM:
  - IDLE → RUN on first counted eop.
  - RUN → DRAIN when pkt_in_cnt reaches PKT_LIMIT.
  - DRAIN → DONE when res_cnt == PKT_LIMIT.
  - Any of IDLE/RUN/DRAIN → FAIL the cycle after any fault bit becomes set (fault wins over a same-cycle DONE condition).
  - DONE and FAIL are terminal until rst.
- done = state ∈ {DONE, FAIL}; pass = state == DONE & err_cnt == 0. Both are registered outputs.

Decomposition:
- Package crc_chk_pkg holds:
  - chk_state_e {IDLE, RUN, DRAIN, DONE, FAIL}.
  - Fault bit index localparams FLT_OVF=0, FLT_UNF=1, FLT_TMO=2.
  - A status struct bundling counters, fault and done/pass for ILA probing.
- One sub-module, crc_exp_fifo: synchronous FIFO (CRC_WIDTH × FIFO_DEPTH) with push, pop, head, empty, full and synchronous reset flush.

Test Plan:
- PKT_LIMIT=4, 4 packets; exp_crc pushed 2 cycles before each crc_out_vld with matching values → state DONE, res_cnt=4, err_cnt=0, pass=1, fault=0.
- Same stream, 3rd DUT CRC = 0xDEADBEEF vs golden 0x12345678 → err_cnt=1, first_err_idx=2, first_err_got=0xDEADBEEF, first_err_exp=0x12345678, done=1, pass=0.
- crc_out_vld with FIFO empty and exp_vld low → fault=3'b010, FAIL next cycle, done=1, pass=0.
- FIFO_DEPTH=4: 5 pushes with no results → fault=3'b001 on the 5th push; FAIL.
- One eop, no crc_out_vld for MAX_LAT=8 cycles → fault=3'b100 after 8 cycles, FAIL; result arriving in the same cycle the watchdog would hit 8 → no timeout.
- rst pulsed mid-DRAIN with 2 outstanding → next cycle all counters 0, state IDLE, FIFO empty; a subsequent clean 4-packet run → pass=1.
